// File: rtl/sub.sv
// sub: registered small-word incrementer, out_small = in_small + INC after STAGES clocks.
// Latency: exactly STAGES clk edges, one result per cycle.
// Backpressure: none; every edge advances the pipeline (no stall, no handshake).
// Optional build macro SUB_SATURATE_EN: clamp overflow to all-ones instead of wrapping.
module sub #(
    parameter int unsigned         WIDTH  = 32,
    parameter logic [WIDTH-1:0]    INC    = 'd1,
    parameter int unsigned         STAGES = 1
) (
    input  logic             clk,
    input  logic             reset_l,    // active-high asynchronous reset despite the name
    input  logic [WIDTH-1:0] in_small,
    output logic [WIDTH-1:0] out_small
);

    // First-stage next value; the remaining stages just shift.
    logic [WIDTH-1:0] stage0_d;
    logic [WIDTH-1:0] stage_q [STAGES];

`ifdef SUB_SATURATE_EN
    logic [WIDTH:0] sum_ext;

    // Add with one carry bit so overflow is visible, then clamp to all-ones.
    always_comb begin
        sum_ext  = {1'b0, in_small} + {1'b0, INC};
        stage0_d = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
    end
`else
    // Modulo-2**WIDTH add: the carry out is simply dropped.
    always_comb begin
        stage0_d = in_small + INC;
    end
`endif

    // Pipeline shift; reset clears every stage immediately so no in-flight value survives.
    always_ff @(posedge clk or posedge reset_l) begin
        if (reset_l) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= stage0_d;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Output comes straight from the last flop: no combinational path from in_small.
    assign out_small = stage_q[STAGES-1];

endmodule

// File: tb/tb_sub.sv
// tb_sub: directed-vector bench for sub, default build (STAGES=1) plus a STAGES=3 instance.
// Both instances share clock, reset and input; expected values are hand-computed tables.
module tb_sub;

    logic        clk;
    logic        reset_l;
    logic [31:0] in_small;
    logic [31:0] out1;
    logic [31:0] out3;

    int n_tests = 0;
    int n_fail  = 0;

    sub u_dut1 (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_small  (in_small),
        .out_small (out1)
    );

    sub #(.STAGES(3)) u_dut3 (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_small  (in_small),
        .out_small (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus and hand-computed in+1 results.
    localparam int NVEC = 11;
    logic [31:0] vec [NVEC] = '{32'h0000_0010, 32'h1, 32'h2, 32'h3, 32'h4,
                                32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE,
                                32'h5, 32'h6, 32'h6};
`ifdef SUB_SATURATE_EN
    logic [31:0] exp1 [NVEC] = '{32'h0000_0011, 32'h2, 32'h3, 32'h4, 32'h5,
                                 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'h6, 32'h7, 32'h7};
`else
    logic [31:0] exp1 [NVEC] = '{32'h0000_0011, 32'h2, 32'h3, 32'h4, 32'h5,
                                 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'h6, 32'h7, 32'h7};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold;
        reset_l  = 1'b0;
        in_small = 32'h0;
        #1;
        reset_l  = 1'b1;
        #1;
        chk("reset_async_d1", out1, 32'h0);
        chk("reset_async_d3", out3, 32'h0);

        in_small = 32'hDEAD_BEEF;
        step();
        step();
        chk("reset_hold_d1", out1, 32'h0);
        chk("reset_hold_d3", out3, 32'h0);

        // Release together with the first operand; the next edge samples it.
        reset_l = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            in_small = vec[i];
            step();
            chk($sformatf("stream_d1_%0d", i), out1, exp1[i]);
            chk($sformatf("stream_d3_%0d", i), out3, (i >= 2) ? exp1[i-2] : 32'h0);
        end

        // Changing the input between edges must not disturb the registered output.
        hold     = out1;
        in_small = 32'h1234_5678;
        #1;
        chk("no_comb_path", out1, hold);

        // Mid-stream reset with full pipeline: clears before any edge.
        #1;
        reset_l = 1'b1;
        #1;
        chk("mid_rst_async_d1", out1, 32'h0);
        chk("mid_rst_async_d3", out3, 32'h0);
        in_small = 32'h0000_0099;
        step();
        chk("mid_rst_edge_d1", out1, 32'h0);
        chk("mid_rst_edge_d3", out3, 32'h0);

        reset_l  = 1'b0;
        in_small = 32'h0000_0020;
        step();
        chk("post_rst0_d1", out1, 32'h0000_0021);
        chk("post_rst0_d3", out3, 32'h0);
        in_small = 32'h0000_0021;
        step();
        chk("post_rst1_d1", out1, 32'h0000_0022);
        chk("post_rst1_d3", out3, 32'h0);
        in_small = 32'h0000_0022;
        step();
        chk("post_rst2_d1", out1, 32'h0000_0023);
        chk("post_rst2_d3", out3, 32'h0000_0021);
        step();
        chk("post_rst3_d3", out3, 32'h0000_0022);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
